// File: rtl/conv_seq_ctrl_if.sv
// Control bundle between the conv sequencer and its datapath/memory.
// Latency: n/a (wires only).
// Backpressure: none; the datapath and memory always accept.
interface conv_seq_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        weight_en;
    logic [3:0]        feature_en;
    logic [7:0]        sel_demux;
    logic [3:0]        acc_en;

    // Sequencer side: consumes start and drives every control output.
    modport master (
        input  start,
        output busy, done, mem_rd, mem_addr,
        output weight_en, feature_en, sel_demux, acc_en
    );

    // Requester / datapath side.
    modport slave (
        output start,
        input  busy, done, mem_rd, mem_addr,
        input  weight_en, feature_en, sel_demux, acc_en
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a 2x2-kernel convolution over a 3x3 map on a 4-lane multiply/accumulate datapath.
// Latency: done pulses 6 + 4*(6+MUL_LAT) cycles after start is accepted; all outputs registered.
// Backpressure: none; start is only sampled in IDLE and is neither queued nor acknowledged otherwise.
module conv_seq_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int WBASE   = 0,
    parameter int FBASE   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    conv_seq_ctrl_if.master     bus
);

    localparam int WAIT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LD_W,
        LD_F,
        MUL_WAIT,
        ACC,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [1:0]        win, win_n;
    logic [WAIT_W-1:0] wcnt, wcnt_n;

    // Registered outputs and their next-cycle values.
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              rd_q, rd_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [3:0]        wen_q, wen_n;
    logic [3:0]        fen_q, fen_n;
    logic [7:0]        sel_q, sel_n;
    logic [3:0]        acc_q, acc_n;

    // Feature coordinates inside the 3x3 map for the fetch issued next cycle.
    logic [1:0]        row, col;

    // State, counters and output registers; synchronous reset aborts any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            win    <= '0;
            wcnt   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            wen_q  <= '0;
            fen_q  <= '0;
            sel_q  <= '0;
            acc_q  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            win    <= win_n;
            wcnt   <= wcnt_n;
            busy_q <= busy_n;
            done_q <= done_n;
            rd_q   <= rd_n;
            addr_q <= addr_n;
            wen_q  <= wen_n;
            fen_q  <= fen_n;
            sel_q  <= sel_n;
            acc_q  <= acc_n;
        end
    end

    // Next state and counters.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        win_n   = win;
        wcnt_n  = wcnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = LD_W;
                    cnt_n   = '0;
                end
            end
            LD_W: begin
                if (cnt == 3'd4) begin
                    state_n = LD_F;
                    cnt_n   = '0;
                    win_n   = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            LD_F: begin
                if (cnt == 3'd4) begin
                    cnt_n  = '0;
                    wcnt_n = '0;
                    state_n = (MUL_LAT == 0) ? ACC : MUL_WAIT;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            MUL_WAIT: begin
                if (wcnt == WAIT_W'(MUL_LAT - 1)) begin
                    state_n = ACC;
                    wcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            ACC: begin
                if (win == 2'd3) begin
                    state_n = DONE;
                end else begin
                    state_n = LD_F;
                    win_n   = win + 2'd1;
                    cnt_n   = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so the registers line up with it.
    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = 1'b0;
        rd_n   = 1'b0;
        addr_n = '0;
        wen_n  = '0;
        fen_n  = '0;
        sel_n  = '0;
        acc_n  = '0;
        row    = {1'b0, win_n[1]} + {1'b0, cnt_n[1]};
        col    = {1'b0, win_n[0]} + {1'b0, cnt_n[0]};
        unique case (state_n)
            LD_W: begin
                // Issue reads on 0..3; capture the previous read's data on 1..4.
                if (cnt_n <= 3'd3) begin
                    rd_n   = 1'b1;
                    addr_n = ADDR_W'(WBASE) + ADDR_W'(cnt_n);
                end
                if (cnt_n != 3'd0) begin
                    wen_n = 4'b1000 >> (cnt_n - 3'd1);
                end
            end
            LD_F: begin
                if (cnt_n <= 3'd3) begin
                    rd_n   = 1'b1;
                    addr_n = ADDR_W'(FBASE) + ADDR_W'(row) * ADDR_W'(3) + ADDR_W'(col);
                end
                if (cnt_n != 3'd0) begin
                    fen_n = 4'b1000 >> (cnt_n - 3'd1);
                end
            end
            ACC: begin
                // All four lanes feed the accumulator for the current window.
                sel_n = {4{win_n}};
                acc_n = 4'b1000 >> win_n;
            end
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mem_rd     = rd_q;
    assign bus.mem_addr   = addr_q;
    assign bus.weight_en  = wen_q;
    assign bus.feature_en = fen_q;
    assign bus.sel_demux  = sel_q;
    assign bus.acc_en     = acc_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: cycle-exact output schedule, start filtering, abort, end-to-end sums.
// Latency: checks done at cycle 34 (MUL_LAT=1) and 30 (MUL_LAT=0).
// Backpressure: none exercised; the sequencer has no stall input.
module tb_conv_seq_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       mem_rd;
        logic [7:0] mem_addr;
        logic [3:0] weight_en;
        logic [3:0] feature_en;
        logic [7:0] sel_demux;
        logic [3:0] acc_en;
    } exp_t;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    conv_seq_ctrl_if #(.ADDR_W(8)) bus1 ();
    conv_seq_ctrl_if #(.ADDR_W(8)) bus0 ();

    conv_seq_ctrl #(.ADDR_W(8), .WBASE(0), .FBASE(4), .MUL_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    conv_seq_ctrl #(.ADDR_W(8), .WBASE(0), .FBASE(4), .MUL_LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed schedule tables for the default map placement.
    int         faddr   [4][4] = '{'{4, 5, 7, 8}, '{5, 6, 8, 9}, '{7, 8, 10, 11}, '{8, 9, 11, 12}};
    logic [7:0] sel_tab [4]    = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    logic [3:0] acc_tab [4]    = '{4'h8, 4'h4, 4'h2, 4'h1};

    // Expected outputs in cycle t after start accepted in cycle 0.
    function automatic exp_t model(input int t, input int ml);
        exp_t e;
        int   p;
        int   k;
        e = '0;
        p = 6 + ml;
        if (t >= 1 && t <= 6 + 4 * p) e.busy = 1'b1;
        if (t == 6 + 4 * p) e.done = 1'b1;
        if (t >= 1 && t <= 4) begin
            e.mem_rd   = 1'b1;
            e.mem_addr = 8'(t - 1);
        end
        if (t >= 2 && t <= 5) e.weight_en = 4'(4'b1000 >> (t - 2));
        for (int w = 0; w < 4; w++) begin
            k = t - (6 + w * p);
            if (k >= 0 && k <= 3) begin
                e.mem_rd   = 1'b1;
                e.mem_addr = 8'(faddr[w][k]);
            end
            if (k >= 1 && k <= 4) e.feature_en = 4'(4'b1000 >> (k - 1));
            if (k == 5 + ml) begin
                e.sel_demux = sel_tab[w];
                e.acc_en    = acc_tab[w];
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, t, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input int t, input exp_t o, input exp_t e);
        chk({tag, ".busy"},       t, 32'(o.busy),       32'(e.busy));
        chk({tag, ".done"},       t, 32'(o.done),       32'(e.done));
        chk({tag, ".mem_rd"},     t, 32'(o.mem_rd),     32'(e.mem_rd));
        chk({tag, ".mem_addr"},   t, 32'(o.mem_addr),   32'(e.mem_addr));
        chk({tag, ".weight_en"},  t, 32'(o.weight_en),  32'(e.weight_en));
        chk({tag, ".feature_en"}, t, 32'(o.feature_en), 32'(e.feature_en));
        chk({tag, ".sel_demux"},  t, 32'(o.sel_demux),  32'(e.sel_demux));
        chk({tag, ".acc_en"},     t, 32'(o.acc_en),     32'(e.acc_en));
    endtask

    exp_t o1, o0;

    task automatic sample();
        o1 = {bus1.busy, bus1.done, bus1.mem_rd, bus1.mem_addr,
              bus1.weight_en, bus1.feature_en, bus1.sel_demux, bus1.acc_en};
        o0 = {bus0.busy, bus0.done, bus0.mem_rd, bus0.mem_addr,
              bus0.weight_en, bus0.feature_en, bus0.sel_demux, bus0.acc_en};
    endtask

    // Memory and datapath model attached to the MUL_LAT=1 sequencer.
    logic [7:0]  mem [256];
    logic [7:0]  data_in;
    logic [7:0]  wreg [4];
    logic [7:0]  freg [4];
    logic [15:0] prod [4];
    logic [15:0] acc  [4];

    always @(posedge clk) begin
        if (rst) begin
            data_in <= '0;
            for (int l = 0; l < 4; l++) begin
                wreg[l] <= '0;
                freg[l] <= '0;
                prod[l] <= '0;
                acc[l]  <= '0;
            end
        end else begin
            if (bus1.mem_rd) data_in <= mem[bus1.mem_addr];
            for (int l = 0; l < 4; l++) begin
                if (bus1.weight_en[3 - l])  wreg[l] <= data_in;
                if (bus1.feature_en[3 - l]) freg[l] <= data_in;
                prod[l] <= 16'(wreg[l]) * 16'(freg[l]);
            end
            for (int j = 0; j < 4; j++) begin
                if (bus1.acc_en[3 - j]) begin
                    logic [15:0] s;
                    s = acc[j];
                    for (int l = 0; l < 4; l++) begin
                        if (int'(bus1.sel_demux[(3 - l) * 2 +: 2]) == j) s = s + prod[l];
                    end
                    acc[j] <= s;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One start pulse on both sequencers, full schedule check, then the convolution sums.
    task automatic run_basic(input string tag);
        bus1.start = 1'b1;
        bus0.start = 1'b1;
        for (int t = 1; t <= 36; t++) begin
            step();
            bus1.start = 1'b0;
            bus0.start = 1'b0;
            sample();
            cmp({tag, "_ml1"}, t, o1, model(t, 1));
            cmp({tag, "_ml0"}, t, o0, model(t, 0));
        end
        chk({tag, "_c11"}, 36, 32'(acc[0]), 32'd37);
        chk({tag, "_c12"}, 36, 32'(acc[1]), 32'd47);
        chk({tag, "_c21"}, 36, 32'(acc[2]), 32'd67);
        chk({tag, "_c22"}, 36, 32'(acc[3]), 32'd77);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
        for (int i = 0; i < 9; i++) mem[4 + i] = 8'(i + 1);

        rst        = 1'b1;
        bus1.start = 1'b0;
        bus0.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        cmp("reset_ml1", 0, o1, '0);
        cmp("reset_ml0", 0, o0, '0);
        rst = 1'b0;
        step();

        // Single start pulse, default map placement.
        run_basic("basic");

        // start held high across the whole run: one run, then a restart from cycle 35.
        bus1.start = 1'b1;
        for (int t = 1; t <= 35; t++) begin
            step();
            sample();
            cmp("held", t, o1, model(t, 1));
        end
        for (int t = 36; t <= 71; t++) begin
            step();
            bus1.start = 1'b0;
            sample();
            cmp("restart", t, o1, model(t - 35, 1));
        end

        // Reset in cycle 15 aborts: everything quiet afterwards, no done.
        bus1.start = 1'b1;
        bus0.start = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            step();
            bus1.start = 1'b0;
            bus0.start = 1'b0;
            sample();
            cmp("pre_abort", t, o1, model(t, 1));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        cmp("abort_ml1", 16, o1, '0);
        cmp("abort_ml0", 16, o0, '0);
        for (int t = 17; t <= 40; t++) begin
            step();
            sample();
            cmp("idle_ml1", t, o1, '0);
            cmp("idle_ml0", t, o0, '0);
        end

        // A fresh start after the abort behaves exactly like the first run.
        run_basic("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
